// File: rtl/turtle_pkg.sv
// rtl/turtle_pkg.sv - shared CPU word width, control-unit select encodings and helpers
package turtle_pkg;

    localparam int WORD_W = 16;

    // Address-bus source select driven by the control unit
    typedef enum logic [1:0] {
        SEL_RAM = 2'd0,
        SEL_RF  = 2'd1,
        SEL_PC  = 2'd2,
        SEL_SP  = 2'd3
    } bus_sel_e;

    // Register-file write-back source select
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_RAM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;
    localparam logic [1:0] WB_SEL_SP  = 2'd3;

    // Occupancy after one edge: +1 push-only, -1 pop-only, unchanged otherwise
    function automatic logic [7:0] next_count(input logic [7:0] cur, input logic push, input logic pop);
        logic [7:0] nxt;
        nxt = cur;
        if (push && !pop) nxt = cur + 8'd1;
        else if (pop && !push) nxt = cur - 8'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - FIFO storage array, one sync write port, one async read port
module fifo_regfile
    import turtle_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are not reset, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - output-port FIFO between the control unit OUT strobe and an external consumer
module out_port_fifo
    import turtle_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_out_valid,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic [DATA_W-1:0] port_data,
    output logic              port_valid,
    input  logic              port_ready,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    input  logic              clr_overflow
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;
    logic [7:0]    count_nxt;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign port_valid = !empty;

    // A pop at the same edge frees a slot, so a push into a full FIFO is still accepted then
    assign pop       = port_valid && port_ready;
    assign push      = cpu_out_valid && (!full || pop);
    assign drop      = cpu_out_valid && full && !pop;
    assign count_nxt = next_count(8'(count), push, pop);

    fifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (cpu_out_data),
        .raddr (rd_ptr),
        .rdata (port_data)
    );

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt[CW-1:0];
        end
    end

    // Sticky drop flag; a drop at the same edge as a clear keeps it set
    always_ff @(posedge clk) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// tb/tb_out_port_fifo.sv - scoreboard testbench for out_port_fifo
module tb_out_port_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_out_valid;
    logic [DATA_W-1:0] cpu_out_data;
    logic [DATA_W-1:0] port_data;
    logic              port_valid;
    logic              port_ready;
    logic              full;
    logic              empty;
    logic [3:0]        count;
    logic              overflow;
    logic              clr_overflow;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] sb [$];
    logic              m_ovf;
    logic [DATA_W-1:0] last_pop;

    out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_out_valid (cpu_out_valid),
        .cpu_out_data  (cpu_out_data),
        .port_data     (port_data),
        .port_valid    (port_valid),
        .port_ready    (port_ready),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Update the model with the inputs about to be sampled, take one edge, then check occupancy and flag
    task automatic step();
        int  sz;
        bit  do_pop;
        logic [DATA_W-1:0] exp;
        sz = sb.size();
        do_pop = rst_n && (port_valid === 1'b1) && port_ready;
        if (rst_n) begin
            if (do_pop) begin
                if (sz == 0) check("pop_when_model_empty", 32'd1, 32'd0);
                else begin
                    exp = sb.pop_front();
                    check("port_data", 32'(port_data), 32'(exp));
                    last_pop = port_data;
                end
            end
            if (cpu_out_valid) begin
                if (sz < DEPTH || do_pop) sb.push_back(cpu_out_data);
                else m_ovf = 1'b1;
            end else if (clr_overflow) m_ovf = 1'b0;
            if (cpu_out_valid && clr_overflow && (sz < DEPTH || do_pop)) m_ovf = 1'b0;
        end else begin
            sb.delete();
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(sb.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_valid"}, 32'(port_valid), 32'(sb.size() != 0));
        check({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
        check({tag, "_full"},  32'(full),  32'(sb.size() == DEPTH));
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, input logic rdy);
        cpu_out_valid = 1'b1;
        cpu_out_data  = d;
        port_ready    = rdy;
        step();
        cpu_out_valid = 1'b0;
        cpu_out_data  = 'x;
    endtask

    task automatic drain();
        int n;
        n = 0;
        port_ready = 1'b1;
        while (port_valid === 1'b1 && n < 20) begin
            step();
            n++;
        end
        port_ready = 1'b0;
        check("drain_bounded", 32'(n < 20), 32'd1);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check_flags("drained");
    endtask

    initial begin
        rst_n = 1'b0; cpu_out_valid = 1'b0; cpu_out_data = '0;
        port_ready = 1'b0; clr_overflow = 1'b0; m_ovf = 1'b0; last_pop = '0;
        #1;

        // 1: reset then idle
        step(); step();
        check_flags("reset");
        rst_n = 1'b1;
        step();
        check_flags("idle");

        // 2: single word, stalled for 5 cycles, then popped
        cpu_out_valid = 1'b1; cpu_out_data = 16'hBEEF;
        check("no_bypass_valid", 32'(port_valid), 32'd0);
        step();
        cpu_out_valid = 1'b0; cpu_out_data = 'x;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(port_valid), 32'd1);
            check("stall_data", 32'(port_data), 32'h0000BEEF);
            step();
        end
        port_ready = 1'b1;
        step();
        port_ready = 1'b0;
        check("single_last", 32'(last_pop), 32'h0000BEEF);
        check_flags("single_done");

        // 3: fill and overflow; 0009 is dropped
        for (int i = 1; i <= 9; i++) push_word(16'(i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_ovf", 32'(overflow), 32'd1);
        drain();
        check("fill_last", 32'(last_pop), 32'h00000008);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("clr_after_fill", 32'(overflow), 32'd0);

        // 4: push while full with a coincident pop
        for (int i = 0; i < 8; i++) push_word(16'h1000 + 16'(i), 1'b0);
        check_flags("full4");
        push_word(16'hA5A5, 1'b1);
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        drain();
        check("fullpp_last", 32'(last_pop), 32'h0000A5A5);

        // 5: wrap-around, 20 pushes, ready on alternate cycles
        for (int i = 0; i < 40; i++) begin
            cpu_out_valid = (i % 2 == 0);
            cpu_out_data  = (i % 2 == 0) ? 16'($urandom) : 'x;
            port_ready    = (i % 2 == 1);
            step();
            check("wrap_le8", 32'(count <= 4'd8), 32'd1);
        end
        cpu_out_valid = 1'b0;
        drain();
        check("wrap_ovf", 32'(overflow), 32'd0);

        // 6: reset mid-operation, then overflow clear rules
        for (int i = 0; i < 3; i++) push_word(16'h3000 + 16'(i), 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_valid", 32'(port_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) push_word(16'h4000 + 16'(i), 1'b0);
        clr_overflow = 1'b1;
        push_word(16'hDEAD, 1'b0);
        clr_overflow = 1'b0;
        check("set_wins", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("lone_clr", 32'(overflow), 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
